acond_pulsadores: RTL
=====================

// Module: acond_pulsadores
// PURPOSE
//  Input conditioning stage for the board push-buttons (KEY[2:1]). It sits directly upstream of the
//  speed-control FSM and feeds it clean signals instead of raw, bouncing, asynchronous KEY levels.
//  Per key it provides: synchronisation, debounce, a one-cycle press pulse, a one-cycle release
//  pulse, and optional auto-repeat while the key is held.
//  All keys are handled independently; arbitration between keys is the consumer's job.
// PARAMETERS
//  N_KEYS           2           number of independent keys handled
//  DEBOUNCE_CYCLES  500_000     consecutive stable cycles needed to accept a level change (10 ms @ 50 MHz); >=1
//  REPEAT_EN        1           1: auto-repeat while held; 0: one pulse per press
//  REPEAT_DELAY     25_000_000  cycles from press pulse to first repeat pulse (500 ms); >=1
//  REPEAT_PERIOD    5_000_000   cycles between subsequent repeat pulses (100 ms); >=1
// PORTS
//  CLK      in   1       system clock (CLOCK_50)
//  RSTn     in   1       asynchronous active-low reset
//  KEYn     in   N_KEYS  raw key levels, active-low (0 = pressed), asynchronous to CLK
//  PRESSED  out  N_KEYS  debounced key level, active-high
//  PULSE    out  N_KEYS  one-cycle strobe on accepted press and on each repeat
//  RELEASE  out  N_KEYS  one-cycle strobe on accepted release
// BEHAVIOUR
//  Reset (RSTn=0, asynchronous):
//   - sync flops = 1 (released); stable level = released.
//   - debounce and repeat counters = 0; per-key FSM = IDLE.
//   - PRESSED = PULSE = RELEASE = 0.
//   - Reset mid-press: the key is treated as released. A key still held at reset exit must be
//     re-accepted through the full debounce before any PULSE is issued.
//  Synchroniser:
//   - 2-FF chain per key; sync_out is KEYn delayed by 2 edges.
//  Debounce (per key):
//   - Counter increments on every cycle where sync_out != stable; it clears on any cycle where
//     they are equal.
//   - When the counter has counted DEBOUNCE_CYCLES consecutive mismatches, stable toggles and the
//     counter clears.
//   - Latency: take the edge that first samples the new raw level as edge 0. stable (and
//     PRESSED/PULSE/RELEASE) change at edge 2+DEBOUNCE_CYCLES.
//   - Glitches shorter than DEBOUNCE_CYCLES produce no output.
//  Per-key FSM, states IDLE, DELAY, REPEAT:
//   - IDLE:   stable becomes pressed -> PULSE=1 for that cycle, PRESSED=1, load repeat timer.
//             Go to DELAY if REPEAT_EN=1, else to REPEAT with the timer disabled.
//   - DELAY:  timer reaches REPEAT_DELAY cycles after the press pulse -> PULSE=1, reload
//             REPEAT_PERIOD, go to REPEAT.
//   - REPEAT: every REPEAT_PERIOD cycles -> PULSE=1 (only when REPEAT_EN=1).
//   - Any state, stable becomes released -> RELEASE=1 for one cycle, PRESSED=0, timer cleared,
//     go to IDLE. A release on the same cycle as a due repeat wins: no PULSE is issued.
//  Arithmetic and width rules:
//   - Counter widths = $clog2(param+1). Counters reload and never wrap.
//   - PULSE and RELEASE are never both 1 on the same key in the same cycle.
//   - Outputs are registered; no combinational path from KEYn to any output.
//  Simultaneous presses on several keys: each key's outputs behave exactly as if it were alone.
// TESTING (bench params: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, N_KEYS=2)
//  1 Reset, KEYn=2'b11 -> all outputs 0. Drop RSTn during a hold -> outputs 0 immediately, with no
//    clock edge needed.
//  2 KEYn[0] 1->0 sampled at edge 0, held -> PRESSED[0]=1 and PULSE[0]=1 at edge 6; PULSE[0] is 0
//    at edge 7.
//  3 KEYn[0] toggles every 2 cycles for 20 cycles, then stays 0 -> no PULSE during the bounce;
//    exactly one PULSE 6 edges after the last toggle.
//  4 Hold KEYn[1] low -> PULSE[1] at edges t, t+10, t+13, t+16.
//    Then release -> RELEASE[1] 6 edges later, no further PULSE.
//  5 REPEAT_EN=0, hold 50 cycles -> exactly one PULSE, then RELEASE on release.
//  6 Both keys pressed on the same edge -> PULSE[1:0]=2'b11 on the same cycle; the repeat
//    sequences run independently.

Source files
------------

// File: rtl/acond_pulsadores_if.sv
// Key-conditioning bus: raw active-low key levels in, conditioned key events out.
interface acond_pulsadores_if #(
  parameter int N_KEYS = 2
);
  logic [N_KEYS-1:0] KEYn;
  logic [N_KEYS-1:0] PRESSED;
  logic [N_KEYS-1:0] PULSE;
  logic [N_KEYS-1:0] RELEASE;

  // Producer of raw key levels / consumer of conditioned events
  modport master (output KEYn, input PRESSED, input PULSE, input RELEASE);
  // Conditioning block itself
  modport slave (input KEYn, output PRESSED, output PULSE, output RELEASE);
endinterface

// File: rtl/acond_pulsadores.sv
// Push-button conditioning: 2-FF synchroniser, debounce, press/release strobes
// and optional auto-repeat, independently for every key.
module acond_pulsadores #(
  parameter int N_KEYS          = 2,
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000
) (
  input  logic                CLK,
  input  logic                RSTn,
  acond_pulsadores_if.slave   kif
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0]  DB_ONE     = DB_W'(1);
  localparam logic [TMR_W-1:0] TMR_DELAY  = TMR_W'(REPEAT_DELAY);
  localparam logic [TMR_W-1:0] TMR_PERIOD = TMR_W'(REPEAT_PERIOD);
  localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  // Synchroniser stages hold the raw active-low level
  logic [N_KEYS-1:0] sync_p0;
  logic [N_KEYS-1:0] sync_p1;

  // Debounced level, active-high (1 = pressed)
  logic [N_KEYS-1:0] stable_q;
  logic [DB_W-1:0]   db_cnt_q [N_KEYS];
  logic [DB_W-1:0]   db_cnt_d [N_KEYS];
  logic [N_KEYS-1:0] press_evt;
  logic [N_KEYS-1:0] rel_evt;

  state_t            state_q [N_KEYS];
  state_t            state_d [N_KEYS];
  logic [TMR_W-1:0]  tmr_q   [N_KEYS];
  logic [TMR_W-1:0]  tmr_d   [N_KEYS];
  logic [N_KEYS-1:0] repeat_due;
  logic [N_KEYS-1:0] pulse_d;
  logic [N_KEYS-1:0] release_d;
  logic [N_KEYS-1:0] pulse_q;
  logic [N_KEYS-1:0] release_q;

  // ---- stage p0/p1: bring the asynchronous key levels into the clock domain
  // Two-flop synchroniser; reset value is "released"
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sync_p0 <= '1;
      sync_p1 <= '1;
    end else begin
      sync_p0 <= kif.KEYn;
      sync_p1 <= sync_p0;
    end
  end

  // ---- debounce: accept a level only after DEBOUNCE_CYCLES+1 consecutive mismatches
  // Count mismatches; flag a press/release when the run is long enough
  always_comb begin
    for (int k = 0; k < N_KEYS; k++) begin
      press_evt[k] = 1'b0;
      rel_evt[k]   = 1'b0;
      db_cnt_d[k]  = '0;
      if (!sync_p1[k] != stable_q[k]) begin
        if (db_cnt_q[k] == DB_LAST) begin
          press_evt[k] = !stable_q[k];
          rel_evt[k]   = stable_q[k];
        end else begin
          db_cnt_d[k] = db_cnt_q[k] + DB_ONE;
        end
      end
    end
  end

  // Debounced level and mismatch counters
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      stable_q <= '0;
      for (int k = 0; k < N_KEYS; k++) db_cnt_q[k] <= '0;
    end else begin
      stable_q <= stable_q ^ (press_evt | rel_evt);
      for (int k = 0; k < N_KEYS; k++) db_cnt_q[k] <= db_cnt_d[k];
    end
  end

  // ---- per-key event FSM
  // State register
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int k = 0; k < N_KEYS; k++) state_q[k] <= IDLE;
    end else begin
      for (int k = 0; k < N_KEYS; k++) state_q[k] <= state_d[k];
    end
  end

  // Next-state logic; a release always returns to IDLE
  always_comb begin
    for (int k = 0; k < N_KEYS; k++) begin
      state_d[k] = state_q[k];
      case (state_q[k])
        IDLE:    if (press_evt[k]) state_d[k] = (REPEAT_EN != 0) ? DELAY : REPEAT;
        DELAY:   if (rel_evt[k]) state_d[k] = IDLE;
                 else if (tmr_q[k] == TMR_ONE) state_d[k] = REPEAT;
        REPEAT:  if (rel_evt[k]) state_d[k] = IDLE;
        default: state_d[k] = IDLE;
      endcase
    end
  end

  // Output/timer logic; a release suppresses a repeat due on the same cycle
  always_comb begin
    for (int k = 0; k < N_KEYS; k++) begin
      repeat_due[k] = (REPEAT_EN != 0) && (state_q[k] != IDLE) && (tmr_q[k] == TMR_ONE);
      pulse_d[k]    = press_evt[k] | (repeat_due[k] & !rel_evt[k]);
      release_d[k]  = rel_evt[k];
      tmr_d[k]      = tmr_q[k];
      if (rel_evt[k]) begin
        tmr_d[k] = '0;
      end else if (press_evt[k]) begin
        tmr_d[k] = (REPEAT_EN != 0) ? TMR_DELAY : '0;
      end else if (repeat_due[k]) begin
        tmr_d[k] = TMR_PERIOD;
      end else if ((state_q[k] != IDLE) && (tmr_q[k] != '0)) begin
        tmr_d[k] = tmr_q[k] - TMR_ONE;
      end
    end
  end

  // Registered strobes and repeat timers
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      pulse_q   <= '0;
      release_q <= '0;
      for (int k = 0; k < N_KEYS; k++) tmr_q[k] <= '0;
    end else begin
      pulse_q   <= pulse_d;
      release_q <= release_d;
      for (int k = 0; k < N_KEYS; k++) tmr_q[k] <= tmr_d[k];
    end
  end

  assign kif.PRESSED = stable_q;
  assign kif.PULSE   = pulse_q;
  assign kif.RELEASE = release_q;

endmodule
